leb128_i32_stream: RTL and testbench
====================================

# leb128_i32_stream

Streaming front-end for the combinational `unpack_i32` signed-LEB128 decoder. Accepts LEB128 bytes one per cycle over a valid/ready handshake, collects them into the five byte slots `unpack_i32` expects, and detects the terminating byte. It then presents the decoded 32-bit signed value on a valid/ready output port with the encoded byte count. Sits between a byte-wide bytecode/section reader and any consumer of i32 immediates.

## Interface
- No parameters. Maximum byte count is fixed at 5 by `unpack_i32`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  LEB128 byte; bit 7 is the continuation flag.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `out_data`  out  32  decoded signed value.
- `out_len`  out  3  bytes consumed by this value, 1..5.
- `out_err`  out  1  malformed encoding; see Configuration.
- `out_valid`  out  1  `out_data`, `out_len` and `out_err` are valid.
- `out_ready`  in  1  consumer takes the value this cycle.

## Operation
- States: `COLLECT` and `HOLD`.
- Byte slots `b0..b4` are 8-bit registers. Index counter `idx` is 3 bits, range 0..4.
- In `COLLECT`:
  - `in_ready`=1 and `out_valid`=0.
  - A byte is accepted when `in_valid`&`in_ready`. It is written to `b[idx]`.
  - If `in_data[7]`==0 or `idx`==4, this is the terminating byte: `out_len`←`idx`+1 and the state goes to `HOLD`.
  - Otherwise `idx`←`idx`+1.
- In `HOLD`:
  - `in_ready`=0 and `out_valid`=1.
  - `out_data` is `unpack_i32(b0..b4)`.
  - Slots above the terminator stay zero. This is guaranteed by the clear described below.
- On `out_valid`&`out_ready` in `HOLD`: all slots are cleared to 0, `idx`←0, and the state returns to `COLLECT`.
- `out_data`, `out_len` and `out_err` are stable for the whole `HOLD` interval.
- A 5th byte with bit 7 set still terminates. It is never carried into the next value.
- `in_valid` low in `COLLECT` is a bubble: the partial value is retained indefinitely.
- Reset, including mid-value: state←`COLLECT`, `idx`←0, all slots←0, `out_valid`=0, `out_len`=0, `out_err`=0, `in_ready`=1 once `rstn` deasserts. A partial value in flight is discarded.

## Timing
- `out_valid` rises the cycle after the terminating byte is accepted.
- An n-byte value occupies n+1 cycles minimum: n accept cycles plus one `HOLD` cycle with `out_ready`=1.
- The next value's first byte can be accepted the cycle after the output handshake.
- Input is not accepted while in `HOLD`. There is no skid buffer.
- `out_data` is combinational from the registered slots through `unpack_i32`. There is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on state, never on `out_ready`.

## Configuration
- `LEB128_OVERLONG_CHECK_EN`
- Defined: `out_err` is registered when the terminator is accepted. It is set if the 5th byte has bit 7=1, or if the 5th byte's bits [6:4] are not all equal to its bit 3 (i.e. the value exceeds i32 range). `out_data` still shows the `unpack_i32` result; the consumer decides what to do with it.
- Not defined: `out_err` is tied to 0. Such inputs decode silently with the upper bits truncated.

## Structure
- `leb128_pkg`:
  - `LEB128_MAX_BYTES`=5.
  - `LEB128_CONT_BIT`=7.
  - State encoding constants `ST_COLLECT` and `ST_HOLD`.
- Single sub-module: an instance of the existing `unpack_i32` on `b0..b4`. The FSM, counter and slots are in `leb128_i32_stream`.

## Test plan
- Reset then `00`, `out_ready`=1 → `out_valid` one cycle later; `out_data`=0, `out_len`=1, `out_err`=0.
- `9b f1 59` back-to-back → `out_data`=0xFFF6789B (−624485), `out_len`=3.
- `7f`, then `3f` with `out_ready` held low 4 cycles → first output −1 (`out_len`=1) held stable with `in_ready`=0 throughout; after the handshake, second output 63.
- `80 80 80 80 78` → 0x80000000, `out_len`=5, `out_err`=0. `ff ff ff ff 07` → 0x7FFFFFFF, `out_len`=5, `out_err`=0.
- `80 80 80 80 80` → `out_len`=5. `out_err`=1 with `LEB128_OVERLONG_CHECK_EN`, 0 without. `ff ff ff ff 0f` → `out_err`=1 with the macro.
- `9b f1`, assert `rstn`=0 for one cycle, then `05` → single output 5 with `out_len`=1; no trace of the aborted value.

Source files
------------

// File: rtl/leb128_pkg.sv
// Shared constants and FSM state type for the LEB128 i32 streaming decoder.
package leb128_pkg;

    localparam int          LEB128_MAX_BYTES = 5;
    localparam int          LEB128_CONT_BIT  = 7;
    localparam logic [2:0]  LEB128_LAST_IDX  = 3'(LEB128_MAX_BYTES - 1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/leb128_i32_stream_unpack_i32.sv
// unpack_i32: combinational signed-LEB128 decode of up to five byte slots.
// The first slot with the continuation bit clear terminates the value; slot 4
// always terminates. Only the low 4 bits of slot 4 fit into 32 bits.
module unpack_i32 (
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [7:0]  b4,
    output logic [31:0] value
);

    // Sign-extend from the payload MSB of the terminating byte.
    always_comb begin
        value = {b4[3:0], b3[6:0], b2[6:0], b1[6:0], b0[6:0]};
        if (!b0[7]) begin
            value = {{25{b0[6]}}, b0[6:0]};
        end else if (!b1[7]) begin
            value = {{18{b1[6]}}, b1[6:0], b0[6:0]};
        end else if (!b2[7]) begin
            value = {{11{b2[6]}}, b2[6:0], b1[6:0], b0[6:0]};
        end else if (!b3[7]) begin
            value = {{4{b3[6]}}, b3[6:0], b2[6:0], b1[6:0], b0[6:0]};
        end
    end

endmodule

// File: rtl/leb128_i32_stream.sv
// leb128_i32_stream: byte-serial valid/ready front-end for unpack_i32.
// Collects up to five LEB128 bytes, then holds the decoded i32 until taken.
// Optional macro LEB128_OVERLONG_CHECK_EN enables out_err for encodings
// whose fifth byte continues or exceeds the i32 range.
//
// state      | meaning
// ST_COLLECT | accepting bytes into slot[idx]
// ST_HOLD    | decoded value presented, waiting for out_ready
module leb128_i32_stream
    import leb128_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_len,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    state_e      state_q;
    logic [2:0]  idx_q;
    logic [2:0]  len_q;
    logic [7:0]  slot_q [LEB128_MAX_BYTES];
    logic        last_d;
    logic [2:0]  len_d;

    assign last_d = !in_data[LEB128_CONT_BIT] || (idx_q == LEB128_LAST_IDX);
    assign len_d  = idx_q + 3'd1;

`ifdef LEB128_OVERLONG_CHECK_EN
    logic err_q;
    logic err_d;

    // Fifth byte must terminate and must be a proper sign extension of bit 3.
    assign err_d = (idx_q == LEB128_LAST_IDX) &&
                   (in_data[LEB128_CONT_BIT] || (in_data[6:4] != {3{in_data[3]}}));
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // Collect/hold FSM with slot, index and length registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_COLLECT;
            idx_q   <= 3'd0;
            len_q   <= 3'd0;
            for (int i = 0; i < LEB128_MAX_BYTES; i++) slot_q[i] <= 8'h00;
`ifdef LEB128_OVERLONG_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (in_valid) begin
                        slot_q[idx_q] <= in_data;
                        if (last_d) begin
                            len_q   <= len_d;
                            state_q <= ST_HOLD;
`ifdef LEB128_OVERLONG_CHECK_EN
                            err_q   <= err_d;
`endif
                        end else begin
                            idx_q <= len_d;
                        end
                    end
                end
                ST_HOLD: begin
                    // Clearing all slots keeps unused upper slots zero for the next value.
                    if (out_ready) begin
                        for (int i = 0; i < LEB128_MAX_BYTES; i++) slot_q[i] <= 8'h00;
                        idx_q   <= 3'd0;
                        state_q <= ST_COLLECT;
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = (state_q == ST_HOLD);
    assign out_len   = len_q;

    unpack_i32 u_unpack (
        .b0    (slot_q[0]),
        .b1    (slot_q[1]),
        .b2    (slot_q[2]),
        .b3    (slot_q[3]),
        .b4    (slot_q[4]),
        .value (out_data)
    );

endmodule

// File: tb/tb_leb128_i32_stream.sv
// Directed testbench for leb128_i32_stream.
module tb_leb128_i32_stream;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_len;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int vectors = 0;
    int fails   = 0;

`ifdef LEB128_OVERLONG_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    leb128_i32_stream dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d,
                              input logic [2:0] l, input logic e);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".data"},  out_data, d);
        chk({tag, ".len"},   32'(out_len), 32'(l));
        chk({tag, ".err"},   32'(out_err), 32'(e));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    endtask

    // Present one byte for exactly one rising edge; sampling happens #1 later.
    task automatic push(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.len",   32'(out_len), 32'd0);
        chk("rst.err",   32'(out_err), 32'd0);
        @(negedge clk); rstn = 1'b1;
        tick();
        expect_idle("rst");

        // Single zero byte
        out_ready = 1'b1;
        push(8'h00);
        expect_out("zero", 32'h0, 3'd1, 1'b0);
        tick();
        expect_idle("zero.after");

        // Three-byte negative, back to back
        push(8'h9b); push(8'hf1); push(8'h59);
        expect_out("neg3", 32'hFFF6789B, 3'd3, 1'b0);
        tick();
        expect_idle("neg3.after");

        // Hold -1 under backpressure while a byte waits on the input
        out_ready = 1'b0;
        push(8'h7f);
        expect_out("m1.h0", 32'hFFFFFFFF, 3'd1, 1'b0);
        in_data = 8'h3f; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("m1.hold", 32'hFFFFFFFF, 3'd1, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        expect_idle("m1.after");
        tick();
        in_valid = 1'b0;
        expect_out("p63", 32'd63, 3'd1, 1'b0);
        tick();
        expect_idle("p63.after");

        // Five-byte extremes
        push(8'h80); push(8'h80); push(8'h80); push(8'h80); push(8'h78);
        expect_out("min", 32'h80000000, 3'd5, 1'b0);
        tick();
        push(8'hff); push(8'hff); push(8'hff); push(8'hff); push(8'h07);
        expect_out("max", 32'h7FFFFFFF, 3'd5, 1'b0);
        tick();

        // Overlong: fifth byte continues, then out-of-range fifth byte
        push(8'h80); push(8'h80); push(8'h80); push(8'h80); push(8'h80);
        expect_out("ovl.cont", 32'h0, 3'd5, CHK);
        tick();
        expect_idle("ovl.cont.after");
        push(8'hff); push(8'hff); push(8'hff); push(8'hff); push(8'h0f);
        expect_out("ovl.range", 32'hFFFFFFFF, 3'd5, CHK);
        tick();

        // Reset mid-value discards the partial encoding
        push(8'h9b); push(8'hf1);
        rstn = 1'b0;
        tick();
        chk("mrst.len", 32'(out_len), 32'd0);
        rstn = 1'b1;
        expect_idle("mrst");
        push(8'h05);
        expect_out("mrst.five", 32'd5, 3'd1, 1'b0);
        tick();
        expect_idle("mrst.after");
        tick(); tick();
        expect_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
